// File: rtl/counter_arbiter_pkg.sv
// Shared types and helpers for the time-shared counter arbiter.
package counter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int COUNT_W_DEF = 2;

  // Upper bounds for the generic target extractor.
  localparam int TGT_VEC_MAX = 1024;
  localparam int TGT_MAX_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [TGT_MAX_W-1:0] target_at(
    input logic [TGT_VEC_MAX-1:0] vec,
    input int                     k,
    input int                     w
  );
    logic [TGT_MAX_W-1:0] t;
    t = '0;
    for (int i = 0; i < TGT_MAX_W; i++) begin
      if (i < w && (k * w + i) < TGT_VEC_MAX) t[i] = vec[k * w + i];
    end
    return t;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester-side bundle of the counter arbiter: request/target in, grant/count/done out.
interface counter_arbiter_if
  import counter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int COUNT_W = COUNT_W_DEF
);
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*COUNT_W-1:0] target_i;
  logic [NUM_REQ-1:0]         grant_o;
  logic                       busy_o;
  logic [COUNT_W-1:0]         count_o;
  logic [NUM_REQ-1:0]         done_o;

  modport master (
    output req_i, target_i,
    input  grant_o, busy_o, count_o, done_o
  );

  modport slave (
    input  req_i, target_i,
    output grant_o, busy_o, count_o, done_o
  );
endinterface

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to accept the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);
  always_comb begin
    int pos;
    pos = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    // Scan from the farthest offset down so the closest request wins last.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = (int'(ptr) + off) % NUM_REQ;
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
        vld      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/counter_arbiter.sv
// Time-shares one up-counter: grant one edge after request, count 0..target, one-cycle done.
// Requesters hold req until done; dropping req mid-run aborts without done and still rotates priority.
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  counter_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                   state;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         gidx;
  logic [IDX_W-1:0]         gidx_nxt;
  logic [IDX_W-1:0]         win_idx;
  logic [NUM_REQ-1:0]       win;
  logic                     win_vld;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [COUNT_W-1:0]       count;
  logic [COUNT_W-1:0]       tgt;
  logic [TGT_VEC_MAX-1:0]   tgt_vec;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_i),
    .ptr (ptr),
    .gnt (win),
    .idx (win_idx),
    .vld (win_vld)
  );

  assign tgt_vec  = TGT_VEC_MAX'(bus.target_i);
  assign gidx_nxt = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
      done  <= '0;
      count <= '0;
      tgt   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          count <= '0;
          if (win_vld) begin
            grant <= win;
            gidx  <= win_idx;
            tgt   <= COUNT_W'(target_at(tgt_vec, int'(win_idx), COUNT_W));
            state <= RUN;
          end
        end
        RUN: begin
          // A dropped request takes precedence over reaching the target.
          if (!bus.req_i[gidx]) begin
            grant <= '0;
            count <= '0;
            ptr   <= gidx_nxt;
            state <= IDLE;
          end else if (count == tgt) begin
            grant <= '0;
            done  <= grant;
            ptr   <= gidx_nxt;
            state <= DONE;
          end else begin
            count <= count + COUNT_W'(1);
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant_o = grant;
  assign bus.done_o  = done;
  assign bus.count_o = count;
  assign bus.busy_o  = (state != IDLE);
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one COUNT_W-bit up-counter among NUM_REQ requesters. The block arbitrates round-robin, grants the counter to one requester, and runs it from 0 up to that requester's target. It then pulses a per-requester completion strobe and re-arbitrates. It is the sequencing layer above the free-running 2-bit counter and turns that counter into a scheduled, time-shared resource.

## Interface
- NUM_REQ, default 4: number of requesters; must be ≥2.
- COUNT_W, default 2: counter width; targets and count_o use this width.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level; held until the requester's done_o bit pulses.
- target_i  input  NUM_REQ*COUNT_W  packed targets; requester k uses bits [k*COUNT_W +: COUNT_W]; sampled only at grant.
- grant_o  output  NUM_REQ  one-hot grant; all-zero when no requester is being served.
- busy_o  output  1  high whenever state ≠ IDLE.
- count_o  output  COUNT_W  current count of the shared counter.
- done_o  output  NUM_REQ  one-cycle completion pulse to the served requester.

## Operation
- Reset values: state IDLE, grant_o 0, busy_o 0, count_o 0, done_o 0, priority pointer 0 (requester 0 has top priority), latched target 0.
- **IDLE**
  - If req_i ≠ 0, select the first asserted bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register the one-hot grant, latch that requester's target, keep count_o = 0, and go to RUN.
  - If req_i = 0, stay in IDLE.
- **RUN**
  - If count_o == latched target, go to DONE and hold count_o.
  - Otherwise count_o increments by 1.
  - A target of T therefore gives T+1 RUN cycles (0..T).
  - Count never wraps: T ≤ 2^COUNT_W−1, and counting stops at T.
- **DONE**
  - grant_o = 0 and done_o[g] = 1 for exactly this cycle.
  - count_o holds T.
  - Pointer ← (g+1) mod NUM_REQ.
  - Next state is IDLE, where count_o returns to 0.
- **Abort:** if req_i[g] drops during RUN, next state is IDLE with grant_o 0 and count_o 0. No done_o pulse. Pointer still advances to g+1.
- **Target changes:** changes to target_i after grant are ignored.
- **Request timing:**
  - Requests arriving during RUN or DONE wait for IDLE.
  - A requester that keeps req high after its done_o is re-arbitrated at lowest priority. If it is the only requester, it is re-granted after one IDLE cycle.
- **Reset mid-operation:** asynchronously forces all reset values. There is no done_o pulse for the interrupted run.

## Timing
- All outputs are registered except busy_o, which is decoded from state.
- Grant latency: req_i high before edge n → grant_o valid after edge n.
- Full service time for target T is T+3 cycles from grant edge to the next possible grant edge: T+1 RUN, 1 DONE, 1 IDLE.
- Minimum gap between grants is 2 cycles (DONE + IDLE).
- done_o is never asserted together with grant_o.
- At most one bit of each of grant_o and done_o is ever set.

## Structure
- Package counter_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2-bit encoded;
  - the default COUNT_W and NUM_REQ constants;
  - a helper function that extracts target k from the packed vector.
- Sub-module rr_arbiter: parameterized NUM_REQ.
  - Combinational inputs: request vector and pointer.
  - Outputs: one-hot winner and winner index.
  - Pointer storage lives in counter_arbiter.
- counter_arbiter owns the FSM, the counter, the latched target and the pointer.

## Test plan
- Reset: assert rst asynchronously mid-RUN (requester 1, target 3, count 2) → all outputs 0 immediately, pointer 0, no done_o.
- Single request: req_i=4'b0001, target0=2 →
  - grant_o=0001 after edge 1;
  - count_o 0,1,2 on consecutive cycles;
  - done_o=0001 for one cycle;
  - count_o back to 0.
- Round-robin: req_i=4'b1111, all targets 0 → grants in order 0,1,2,3,0, each grant lasting 1 cycle and separated by 2 cycles.
- Boundary targets:
  - target 3 on COUNT_W=2 → count_o reaches 3 with no wrap, then DONE;
  - target 0 → single RUN cycle, done_o next cycle.
- Abort: requester 2 granted with target 3, req_i[2] dropped at count 1 → next cycle IDLE, count_o 0, no done_o, next grant goes to requester 3 if requesting.
- Late and continuous requests:
  - requester 0 holds req through its done_o while requester 3 requests during RUN → requester 3 is granted next, then requester 0;
  - target_i changed during RUN → no effect on the end count.
